// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and register-map constants for the 4-digit 7-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam logic       ADDR_DATA     = 1'b0;
  localparam logic       ADDR_CTRL     = 1'b1;
  localparam int         CTRL_EN       = 0;
  localparam int         CTRL_MASK_LSB = 4;
  localparam logic [3:0] MASK_RST      = 4'hF;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// CPU-side register bus of the display scan controller: single-cycle writes, combinational reads.
interface display_scan_ctrl_if;

  logic        we_i;
  logic        addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output we_i, output addr_i, output wdata_i, input rdata_o);
  modport slave  (input we_i, input addr_i, input wdata_i, output rdata_o);

endinterface

// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display: DATA/CTRL registers, frame-synchronous
// shadow of the digit value, and a DRIVE/BLANK sequencer driving the nibble-mux select and anodes.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 25000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  display_scan_ctrl_if.slave   bus,
  output logic [15:0]          digits_o,
  output logic [1:0]           sel_o,
  output logic [3:0]           an_o,
  output logic                 frame_o
);

  localparam int            CW    = $clog2(REFRESH_DIV) + 1;
  localparam logic [CW-1:0] RLOAD = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLOAD = CW'(BLANK_CYCLES - 1);

  logic [15:0]   data_reg;
  logic          enable;
  logic [3:0]    mask;
  scan_state_t   state;
  logic [CW-1:0] cnt;
  logic          data_wr;
  logic [15:0]   data_next;
  logic          unused_wdata;

  assign unused_wdata = ^{bus.wdata_i[31:8], bus.wdata_i[3:1]};

  // A DATA write landing on a shadow-load edge must win over the stale register value.
  assign data_wr   = bus.we_i && (bus.addr_i == ADDR_DATA);
  assign data_next = data_wr ? bus.wdata_i[15:0] : data_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_reg <= '0;
      enable   <= 1'b0;
      mask     <= MASK_RST;
    end else if (bus.we_i) begin
      if (bus.addr_i == ADDR_DATA) begin
        data_reg <= bus.wdata_i[15:0];
      end else begin
        enable <= bus.wdata_i[CTRL_EN];
        mask   <= bus.wdata_i[CTRL_MASK_LSB +: 4];
      end
    end
  end

  always_comb begin
    bus.rdata_o = '0;
    if (bus.addr_i == ADDR_CTRL) begin
      bus.rdata_o[CTRL_EN]            = enable;
      bus.rdata_o[CTRL_MASK_LSB +: 4] = mask;
    end else begin
      bus.rdata_o[15:0] = data_reg;
    end
  end

  // Clearing enable overrides everything, so a disabled scan never emits a frame pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= OFF;
      cnt      <= '0;
      sel_o    <= 2'd0;
      frame_o  <= 1'b0;
      digits_o <= '0;
    end else begin
      frame_o <= 1'b0;
      if (!enable) begin
        state <= OFF;
        cnt   <= '0;
        sel_o <= 2'd0;
      end else begin
        case (state)
          OFF: begin
            state    <= DRIVE;
            cnt      <= RLOAD;
            sel_o    <= 2'd0;
            digits_o <= data_next;
          end
          DRIVE: begin
            if (cnt == '0) begin
              state <= BLANK;
              cnt   <= BLOAD;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          BLANK: begin
            if (cnt == '0) begin
              state <= DRIVE;
              cnt   <= RLOAD;
              sel_o <= sel_o + 2'd1;
              if (sel_o == 2'd3) begin
                frame_o  <= 1'b1;
                digits_o <= data_next;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: begin
            state <= OFF;
            cnt   <= '0;
            sel_o <= 2'd0;
          end
        endcase
      end
    end
  end

  // Anodes decode straight from registered state so a mask write shows up on the next cycle.
  always_comb begin
    an_o = 4'hF;
    if (state == DRIVE && mask[sel_o]) begin
      an_o[sel_o] = 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with an 8-cycle DRIVE and 2-cycle BLANK (40-cycle frame).
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic        frame;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .bus      (bus),
    .digits_o (digits),
    .sel_o    (sel),
    .an_o     (an),
    .frame_o  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        addr;
    logic [31:0] wdata;
    logic [15:0] exp_digits;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_an;
    logic        exp_frame;
  } vec_t;

  vec_t        tbl [13];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          p;
  logic [15:0] data_m;
  logic [15:0] shadow_m;
  logic [3:0]  mask_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " digits"}, 32'(digits), 32'h0);
    chk({tag, " sel"}, 32'(sel), 32'h0);
    chk({tag, " an"}, 32'(an), 32'hF);
    chk({tag, " frame"}, 32'(frame), 32'h0);
  endtask

  task automatic check_rdata(input string tag, input logic [31:0] exp_data, input logic [31:0] exp_ctrl);
    bus.addr_i = 1'b0;
    #1;
    chk({tag, " rdata DATA"}, bus.rdata_o, exp_data);
    bus.addr_i = 1'b1;
    #1;
    chk({tag, " rdata CTRL"}, bus.rdata_o, exp_ctrl);
    bus.addr_i = 1'b0;
  endtask

  // Reference timing: p counts cycles since DRIVE entry; each digit is 8 lit + 2 blank cycles.
  task automatic checkOutput();
    int          s;
    logic [3:0]  exp_an;
    s      = (p % 40) / 10;
    exp_an = 4'hF;
    if ((p % 10) < 8 && mask_m[s]) exp_an = ~(4'b0001 << s);
    chk($sformatf("p%0d sel", p), 32'(sel), 32'(s));
    chk($sformatf("p%0d an", p), 32'(an), 32'(exp_an));
    chk($sformatf("p%0d frame", p), 32'(frame), 32'(p > 0 && (p % 40) == 0));
    chk($sformatf("p%0d digits", p), 32'(digits), 32'(shadow_m));
  endtask

  task automatic tick();
    logic [15:0] dn;
    logic [3:0]  mn;
    dn = data_m;
    mn = mask_m;
    if (bus.we_i) begin
      if (bus.addr_i == 1'b0) dn = bus.wdata_i[15:0];
      else                    mn = bus.wdata_i[7:4];
    end
    @(posedge clk);
    #1;
    bus.we_i = 1'b0;
    data_m   = dn;
    mask_m   = mn;
    p++;
    if ((p % 40) == 0) shadow_m = data_m;
    checkOutput();
  endtask

  task automatic run_to(input int target);
    while (p < target) tick();
  endtask

  task automatic applyStimulus(input logic addr, input logic [31:0] wdata);
    bus.we_i    = 1'b1;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
  endtask

  task automatic step_raw();
    @(posedge clk);
    #1;
    bus.we_i = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'hDEAD1234, 16'h0000, 2'd0, 4'hF, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h000000F1, 16'h0000, 2'd0, 4'hF, 1'b0};
    for (int i = 2; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 32'h0, 16'h1234, 2'd0, 4'b1110, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 16'h1234, 2'd0, 4'hF, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 16'h1234, 2'd0, 4'hF, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0, 16'h1234, 2'd1, 4'b1101, 1'b0};

    bus.we_i    = 1'b0;
    bus.addr_i  = 1'b0;
    bus.wdata_i = 32'h0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check_rdata("reset", 32'h0, 32'h000000F0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("post-reset idle");

    // Bring-up sequence: DATA write, enable, first digit, blank gap, second digit.
    for (int i = 0; i < 13; i++) begin
      bus.we_i    = tbl[i].we;
      bus.addr_i  = tbl[i].addr;
      bus.wdata_i = tbl[i].wdata;
      step_raw();
      chk($sformatf("vec%0d digits", i), 32'(digits), 32'(tbl[i].exp_digits));
      chk($sformatf("vec%0d sel", i), 32'(sel), 32'(tbl[i].exp_sel));
      chk($sformatf("vec%0d an", i), 32'(an), 32'(tbl[i].exp_an));
      chk($sformatf("vec%0d frame", i), 32'(frame), 32'(tbl[i].exp_frame));
    end
    check_rdata("running", 32'h00001234, 32'h000000F1);

    p        = 10;
    data_m   = 16'h1234;
    shadow_m = 16'h1234;
    mask_m   = 4'hF;

    // Mid-frame DATA write stays hidden until the frame boundary.
    applyStimulus(1'b0, 32'h0000ABCD);
    run_to(39);
    chk("pre-frame digits", 32'(digits), 32'h1234);
    tick();
    chk("frame digits", 32'(digits), 32'hABCD);

    // DATA write on the boundary-load cycle wins.
    run_to(79);
    applyStimulus(1'b0, 32'h00005555);
    tick();
    chk("boundary write digits", 32'(digits), 32'h5555);

    // Mask 0101: only digits 0 and 2 light; frame period unchanged.
    applyStimulus(1'b1, 32'h00000051);
    run_to(182);

    // Disable mid-DRIVE of digit 2.
    applyStimulus(1'b1, 32'h00000050);
    tick();
    for (int i = 0; i < 5; i++) begin
      step_raw();
      chk($sformatf("off%0d sel", i), 32'(sel), 32'h0);
      chk($sformatf("off%0d an", i), 32'(an), 32'hF);
      chk($sformatf("off%0d frame", i), 32'(frame), 32'h0);
      chk($sformatf("off%0d digits", i), 32'(digits), 32'h5555);
    end

    // Re-enable, with a DATA write on the OFF->DRIVE load edge.
    applyStimulus(1'b1, 32'hABCD0F51);
    step_raw();
    chk("reenable idle an", 32'(an), 32'hF);
    chk("reenable idle sel", 32'(sel), 32'h0);
    applyStimulus(1'b0, 32'h00009876);
    step_raw();
    p        = 0;
    data_m   = 16'h9876;
    shadow_m = 16'h9876;
    mask_m   = 4'h5;
    checkOutput();
    check_rdata("reenabled", 32'h00009876, 32'h00000051);
    run_to(12);

    // Mask 0 keeps sequencing and frame pulses but never lights an anode.
    applyStimulus(1'b1, 32'h00000001);
    run_to(48);

    // Asynchronous reset in the middle of BLANK.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    check_rdata("async reset", 32'h0, 32'h000000F0);
    step_raw();
    step_raw();
    check_reset_outputs("held reset");
    @(negedge clk);
    rst_n = 1'b1;
    step_raw();
    check_reset_outputs("after reset release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Memory-mapped scan controller for the 4-digit 7-segment peripheral of the RISC-V SoC.
- Holds the 16-bit display value (4 hex nibbles) and a control register written by the CPU bus.
- Drives the 2-bit select of the downstream 4:1 nibble mux and the active-low anodes.
- Inserts anode blanking (dead time) between digits to suppress ghosting.
- Updates the displayed value only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
REFRESH_DIV, 25000, clock cycles each digit is driven (DRIVE state length); must be >= 2
BLANK_CYCLES, 100, clock cycles all anodes are off between digits (BLANK state length); must be >= 1 and < REFRESH_DIV

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
we_i  input  1  bus write strobe, one cycle per write
addr_i  input  1  register select: 0 = DATA, 1 = CTRL
wdata_i  input  32  bus write data
rdata_o  output  32  combinational read of the register selected by addr_i
digits_o  output  16  shadow (displayed) value; [3:0] feeds mux d0, up to [15:12] feeding d3
sel_o  output  2  digit index to the nibble mux
an_o  output  4  anode enables, active-low, one-hot-low for the current digit
frame_o  output  1  one-cycle pulse when digit 3 completes its BLANK

Behaviour:
- Clock and reset: single clock domain (clk_i). Reset is asynchronous and active-low (rst_n_i). All state is cleared immediately on rst_n_i = 0.
- Reset values:
  - DATA = 0, shadow = 0, so digits_o = 16'h0000.
  - CTRL: enable = 0, mask = 4'hF.
  - sel_o = 0, an_o = 4'hF, frame_o = 0, rdata_o follows the reset registers, state = OFF, counter = 0.
- Registers:
  - DATA[15:0] is writable. Bits [31:16] are ignored on write and read as 0.
  - CTRL bit0 = enable; CTRL bits[7:4] = digit mask (1 = digit lit). Other bits read as 0.
  - A write takes effect on the clock edge when we_i = 1.
- Counter: one down-counter shared by DRIVE and BLANK. Width is $clog2(REFRESH_DIV) + 1.
- FSM states: OFF, DRIVE, BLANK.
  - OFF:
    - an_o = 4'hF, sel_o = 0, counter idle.
    - When enable = 1 (registered), move to DRIVE next cycle, load shadow from DATA and the counter with REFRESH_DIV-1.
  - DRIVE:
    - an_o[sel_o] = 0 if mask[sel_o] = 1, otherwise an_o = 4'hF.
    - The counter decrements. At 0, move to BLANK and load the counter with BLANK_CYCLES-1.
    - DRIVE lasts exactly REFRESH_DIV cycles.
  - BLANK:
    - an_o = 4'hF; sel_o is held.
    - At counter 0: sel_o increments modulo 4, the counter loads REFRESH_DIV-1, and the FSM moves to DRIVE.
    - If sel_o was 3, it wraps to 0, frame_o pulses in that same cycle, and shadow loads DATA.
    - BLANK lasts exactly BLANK_CYCLES cycles.
- Timing: digit period = REFRESH_DIV + BLANK_CYCLES cycles; frame = 4 digit periods.
- Disable: enable cleared in any state moves to OFF on the next cycle. sel_o and the counter reset to 0, an_o = 4'hF, and no frame_o pulse is generated.
- Boundary conditions:
  - DATA write during a frame: digits_o is unchanged until the next frame boundary.
  - DATA write in the same cycle as the frame-boundary load: shadow takes wdata_i[15:0], i.e. the write wins.
  - CTRL write setting enable in OFF, with a DATA write in the same cycle: the first frame shows the new DATA value.
  - Mask change: takes effect immediately on an_o, including mid-DRIVE. It does not alter sequencing.
  - Mask = 0: sequencing and frame_o continue, and an_o stays 4'hF.
  - Reset mid-operation: immediate return to reset values. No partial frame pulse.

Decomposition:
- Package display_pkg holds:
  - state enum scan_state_t {OFF, DRIVE, BLANK};
  - address constants ADDR_DATA = 1'b0, ADDR_CTRL = 1'b1;
  - CTRL bit positions CTRL_EN = 0, CTRL_MASK_LSB = 4;
  - reset constant MASK_RST = 4'hF.
- No sub-module. Register file, FSM and counter are small enough to live in one module. The existing 4:1 nibble mux is instantiated at the top level by the integrator, not inside this block.

Test Plan (REFRESH_DIV = 8, BLANK_CYCLES = 2, so 10-cycle digit period and 40-cycle frame):
1. Reset, write DATA = 16'h1234, then CTRL = 32'h000000F1 -> 8 cycles an_o = 4'b1110 with digits_o = 16'h1234 and sel_o = 0; then 2 cycles an_o = 4'hF; then sel_o = 1 with an_o = 4'b1101. frame_o pulses 40 cycles after DRIVE entry.
2. Write DATA = 16'hABCD while sel_o = 1 -> digits_o stays 16'h1234 until the frame_o cycle, then becomes 16'hABCD.
3. DATA write coinciding with the frame-boundary cycle, value 16'h5555 -> digits_o = 16'h5555 on the next frame.
4. CTRL = 32'h00000051 (mask 4'b0101) -> an_o is low only in DRIVE for sel_o = 0 and 2; sel_o = 1 and 3 keep an_o = 4'hF. frame_o period is still 40 cycles.
5. Clear enable mid-DRIVE with sel_o = 2 -> next cycle state = OFF, an_o = 4'hF, sel_o = 0, no frame_o. Re-enable -> restarts at sel_o = 0 with a full 8-cycle DRIVE.
6. Assert rst_n_i low asynchronously mid-BLANK -> outputs take reset values before the next clock edge; rdata_o = 0 for addr_i = 0 and 32'h000000F0 for addr_i = 1.
